debounce_scan_ctrl: RTL
=======================

Name: debounce_scan_ctrl

Overview:
- Multi-channel button front end that shares one debounce sample datapath among N raw inputs.
- A prescaler generates service slots. A round-robin pointer selects one channel per slot and updates that channel's stability counter and debounced state (read-modify-write).
- Sits between the board push-buttons and the user logic. Emits debounced levels plus one-cycle press/release pulses.

Parameters:
- N, 4, number of button channels (1..16).
- PRESCALE, 1000, clk cycles per service slot (>=2).
- CNT_W, 4, width of each per-channel stability counter. Threshold MAX = 2^CNT_W - 1 consecutive differing samples.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scanning enable; low holds debounced state and idles the scheduler.
- btn  input  N  raw, asynchronous button levels.
- state  output  N  debounced levels.
- press  output  N  one-cycle pulse on a debounced 0->1 change.
- release  output  N  one-cycle pulse on a debounced 1->0 change.
- ch_sel  output  clog2(N) (min 1)  channel serviced in the current slot.
- tick  output  1  high in the cycle whose clock edge performs a service.

Behaviour:
- Reset (async, rst_n=0): state=0, press=0, release=0, ch_sel=0, tick=0. Prescaler, all counters and the FSM are cleared; FSM enters IDLE. All outputs stay at these values until rst_n deasserts. Reset asserted mid-operation aborts any in-progress count with no pulse.
- Input sync: each btn bit passes through a 2-flop synchronizer (clocked always, reset to 0). Only the synchronized value s[i] is used.
- FSM states: IDLE, RUN.
  - IDLE: prescaler=0, ch_sel=0, tick=0, all counters=0, state held. en=1 -> RUN next edge.
  - RUN: prescaler counts 0..PRESCALE-1 and wraps. tick = (prescaler == PRESCALE-1). en=0 -> IDLE next edge; counters are cleared and state is kept.
- Service, on an edge where tick=1, for channel c = ch_sel:
  - s[c] != state[c] and cnt[c] < MAX-1: cnt[c] += 1.
  - s[c] != state[c] and cnt[c] == MAX-1: state[c] toggles, cnt[c]=0, press[c] or release[c] = 1 for exactly the following cycle (registered with the state change).
  - s[c] == state[c]: cnt[c]=0 (glitch rejected).
  - ch_sel advances to (c+1) mod N at the same edge.
- Only one channel is modified per slot. Other channels' counters and state are untouched.
- press/release are never both high on one channel, and at most one channel pulses per cycle.
- Latency: a clean level change is reflected in state after MAX services of that channel. That is MAX*N*PRESCALE cycles, ±N*PRESCALE for slot phase, plus 2 sync cycles.
- Counter width: cnt never exceeds MAX-1, so no wrap. PRESCALE counter width = clog2(PRESCALE).
- Simultaneous en falling with tick: the service edge is not performed; IDLE takes priority.

Test Plan:
- Use N=4, PRESCALE=4, CNT_W=2 (MAX=3), so each channel is serviced every 16 cycles.
- Reset: hold rst_n=0 with btn=4'b1111 -> state=0, press=0, release=0, ch_sel=0, tick=0. Check asynchronously, before any clk edge.
- Clean press on ch1: btn[1] 0->1 held, en=1 -> state[1]=1 after 3 ch1 services (within 32..52 cycles); press[1] high exactly 1 cycle; other outputs unchanged.
- Bounce rejection on ch2: btn[2] toggled 1 for 10 cycles, then 0, repeated 5 times -> state[2] stays 0, no press/release; cnt[2] returns to 0.
- Round-robin: en=1 idle inputs -> tick period 4 cycles; ch_sel sequence 0,1,2,3,0 advancing on each tick.
- Release and simultaneous changes: state=4'b1111, then btn all ->0 -> release pulses on ch0..3 in ch_sel order on distinct cycles 4 apart; final state=0.
- Enable/reset mid-count: 2 services into a ch0 change, drop en -> no toggle, counters cleared; re-enable -> 3 fresh services are needed. Repeat with rst_n pulsed low instead -> all outputs 0 immediately.

Source files
------------

// File: rtl/debounce_scan_ctrl.sv
// -----------------------------------------------------------------------------
// debounce_scan_ctrl
//
// Multi-channel push-button debouncer. A single service datapath is shared by
// all N channels. A prescaler produces one service slot every PRESCALE clocks.
// A round-robin pointer picks one channel per slot and does a read-modify-write
// of that channel's stability counter and debounced level.
//
// A channel's debounced level flips only after MAX = 2^CNT_W - 1 consecutive
// services that all saw the synchronized input differ from the current level.
// Any service that sees agreement clears the counter, which rejects the glitch.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   en             scan enable; low idles the scheduler and holds the levels
//   btn[N]         raw asynchronous button inputs
//   state[N]       debounced levels
//   press[N]       one-cycle pulse on a debounced 0->1 change
//   release_pulse  one-cycle pulse on a debounced 1->0 change. The plain name
//                  "release" is a reserved word in SystemVerilog.
//   ch_sel         channel that the current slot services
//   tick           high in the cycle whose closing clock edge does a service
//
// FSM states:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | scheduler parked: prescaler, ch_sel and counters held at 0
//   ST_RUN  | prescaler running; one channel is serviced per slot
// -----------------------------------------------------------------------------
module debounce_scan_ctrl #(
    parameter  int N        = 4,
    parameter  int PRESCALE = 1000,
    parameter  int CNT_W    = 4,
    localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     btn,
    output logic [N-1:0]     state,
    output logic [N-1:0]     press,
    output logic [N-1:0]     release_pulse,
    output logic [SEL_W-1:0] ch_sel,
    output logic             tick
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
    // The counter never exceeds MAX-1. The service that would reach MAX
    // toggles the level instead of storing MAX.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CNT_W) - 2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    fsm_t              fsm_q, fsm_d;

    logic [N-1:0]      sync1_q, sync2_q;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [SEL_W-1:0]  ch_sel_q, ch_sel_d;
    logic [CNT_W-1:0]  cnt_q [N];
    logic [CNT_W-1:0]  cnt_d [N];
    logic [N-1:0]      state_q, state_d;
    logic [N-1:0]      press_q, press_d;
    logic [N-1:0]      rel_q, rel_d;

    logic              svc;
    logic              sched_clr;
    logic              tick_int;

    // ------------------------------------------------------------------
    // Input synchronizer. It is always clocked, even while scanning is
    // disabled, so the first sample after re-enable is already settled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (en)  fsm_d = ST_RUN;
            ST_RUN:  if (!en) fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // tick is qualified with en. When en falls in the same cycle as the
    // final prescaler count, the edge moves to IDLE and does no service,
    // so tick must not claim that a service happens.
    // ------------------------------------------------------------------
    always_comb begin
        tick_int  = 1'b0;
        sched_clr = 1'b1;
        case (fsm_q)
            ST_RUN: begin
                sched_clr = !en;
                tick_int  = en && (presc_q == PS_LAST);
            end
            default: begin
                sched_clr = 1'b1;
                tick_int  = 1'b0;
            end
        endcase
    end

    assign svc = tick_int;

    // ------------------------------------------------------------------
    // Prescaler and round-robin pointer
    // ------------------------------------------------------------------
    always_comb begin
        presc_d  = presc_q;
        ch_sel_d = ch_sel_q;
        if (sched_clr) begin
            presc_d  = '0;
            ch_sel_d = '0;
        end else if (svc) begin
            presc_d  = '0;
            ch_sel_d = (ch_sel_q == SEL_LAST) ? '0 : ch_sel_q + SEL_W'(1);
        end else begin
            presc_d  = presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            ch_sel_q <= '0;
        end else begin
            presc_q  <= presc_d;
            ch_sel_q <= ch_sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel read-modify-write. Only the channel under ch_sel is
    // touched on a service edge. Leaving RUN clears every counter but
    // keeps the debounced levels.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N; i++) begin
            if (sched_clr) begin
                cnt_d[i] = '0;
            end else if (svc && (ch_sel_q == SEL_W'(i))) begin
                if (sync2_q[i] != state_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ~state_q[i];
                        cnt_d[i]   = '0;
                        if (state_q[i]) begin
                            rel_d[i]   = 1'b1;
                        end else begin
                            press_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign state         = state_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign ch_sel        = ch_sel_q;
    assign tick          = tick_int;

endmodule
